ball_ctrl: RTL



---
 rtl/brick_pkg.sv | 19 +
 rtl/ball_ctrl_axis_step.sv | 36 +++
 rtl/ball_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/brick_pkg.sv
// Shared playfield geometry and ball sequencer state encoding, used by the
// ball controller, the collision checker and the draw FSM.
package brick_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PADDLE_Y = 110;
  localparam int PADDLE_W = 16;

  typedef enum logic [2:0] {
    ST_SERVE     = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_CHECK     = 3'd2,
    ST_MOVE      = 3'd3,
    ST_MISS      = 3'd4,
    ST_OVER      = 3'd5
  } ball_state_t;

endpackage

// File: rtl/ball_ctrl_axis_step.sv
// One-axis position stepper: pos +/- STEP, saturating to [0, LIMIT].
// Sums are formed in 9 bits so that underflow and overflow are seen before
// the clamp. ovf flags a forward step that would pass LIMIT.
module axis_step #(
  parameter int STEP  = 1,
  parameter int LIMIT = 159
) (
  input  logic [7:0] pos,
  input  logic       dir,
  output logic [7:0] next_pos,
  output logic       ovf
);

  logic [8:0] sum;
  logic [8:0] diff;

  // Saturating add/subtract selected by direction.
  always_comb begin
    sum      = {1'b0, pos} + 9'(STEP);
    diff     = {1'b0, pos} - 9'(STEP);
    next_pos = pos;
    ovf      = 1'b0;
    if (dir) begin
      if (sum > 9'(LIMIT)) begin
        next_pos = 8'(LIMIT);
        ovf      = 1'b1;
      end else begin
        next_pos = sum[7:0];
      end
    end else begin
      if (diff[8]) next_pos = 8'd0;
      else         next_pos = diff[7:0];
    end
  end

endmodule

// File: rtl/ball_ctrl.sv
// Frame-rate ball sequencer: parks the ball on the paddle until serve, then
// per frame tick samples collision flags, bounces, and moves the ball.
// Detects bottom-edge misses, counts lives and raises game over.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SERVE      | ball parked on paddle centre, waiting for serve
// WAIT_TICK  | ball live, waiting for next frame tick
// CHECK      | apply hit_x / hit_y from the collision checker to direction
// MOVE       | step position with updated directions; detect bottom miss
// MISS       | lose a life, re-park or end the game
// OVER       | game over, everything frozen until reset
module ball_ctrl #(
  parameter int SCREEN_W = brick_pkg::SCREEN_W,
  parameter int SCREEN_H = brick_pkg::SCREEN_H,
  parameter int PADDLE_Y = brick_pkg::PADDLE_Y,
  parameter int PADDLE_W = brick_pkg::PADDLE_W,
  parameter int SPEED    = 1,
  parameter int LIVES    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [7:0] paddle_x,
  input  logic       hit_x,
  input  logic       hit_y,
  output logic [7:0] ball_x,
  output logic [7:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] lives,
  output logic       in_play,
  output logic       game_over,
  output logic       moved
);

  import brick_pkg::*;

  localparam logic [7:0] PARK_Y = 8'(PADDLE_Y - 1);

  ball_state_t state, state_next;
  logic [7:0]  ball_x_next, ball_y_next;
  logic        dir_x_next, dir_y_next;
  logic [2:0]  lives_next;
  logic        in_play_next, game_over_next, moved_next;
  logic [7:0]  step_x, step_y;
  logic        ovf_x, ovf_y;

  // Paddle centre, clamped so a paddle near the right edge keeps the ball on screen.
  function automatic logic [7:0] park_x(input logic [7:0] px);
    logic [8:0] s;
    s = {1'b0, px} + 9'(PADDLE_W / 2);
    if (s > 9'(SCREEN_W - 1)) return 8'(SCREEN_W - 1);
    return s[7:0];
  endfunction

  axis_step #(.STEP(SPEED), .LIMIT(SCREEN_W - 1)) u_step_x (
    .pos      (ball_x),
    .dir      (dir_x),
    .next_pos (step_x),
    .ovf      (ovf_x)
  );

  axis_step #(.STEP(SPEED), .LIMIT(SCREEN_H - 1)) u_step_y (
    .pos      (ball_y),
    .dir      (dir_y),
    .next_pos (step_y),
    .ovf      (ovf_y)
  );

  // State and all outputs are registered; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_SERVE;
      ball_x    <= park_x(paddle_x);
      ball_y    <= PARK_Y;
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      lives     <= 3'(LIVES);
      in_play   <= 1'b0;
      game_over <= 1'b0;
      moved     <= 1'b0;
    end else begin
      state     <= state_next;
      ball_x    <= ball_x_next;
      ball_y    <= ball_y_next;
      dir_x     <= dir_x_next;
      dir_y     <= dir_y_next;
      lives     <= lives_next;
      in_play   <= in_play_next;
      game_over <= game_over_next;
      moved     <= moved_next;
    end
  end

  // Next-state and next-output logic; every value holds unless a state changes it.
  always_comb begin
    state_next     = state;
    ball_x_next    = ball_x;
    ball_y_next    = ball_y;
    dir_x_next     = dir_x;
    dir_y_next     = dir_y;
    lives_next     = lives;
    in_play_next   = in_play;
    game_over_next = game_over;
    moved_next     = 1'b0;

    case (state)
      ST_SERVE: begin
        ball_x_next  = park_x(paddle_x);
        ball_y_next  = PARK_Y;
        in_play_next = 1'b0;
        if (serve) begin
          dir_x_next   = 1'b1;
          dir_y_next   = 1'b0;
          in_play_next = 1'b1;
          state_next   = ST_WAIT_TICK;
        end
      end
      ST_WAIT_TICK: begin
        if (frame_tick) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        dir_x_next = dir_x ^ hit_x;
        dir_y_next = dir_y ^ hit_y;
        state_next = ST_MOVE;
      end
      ST_MOVE: begin
        ball_x_next = step_x;
        moved_next  = 1'b1;
        // A downward step past the bottom row is a miss; y is left where it was.
        if (dir_y && ovf_y) begin
          state_next = ST_MISS;
        end else begin
          ball_y_next = step_y;
          state_next  = ST_WAIT_TICK;
        end
      end
      ST_MISS: begin
        in_play_next = 1'b0;
        lives_next   = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
        if (lives <= 3'd1) begin
          game_over_next = 1'b1;
          state_next     = ST_OVER;
        end else begin
          ball_x_next = park_x(paddle_x);
          ball_y_next = PARK_Y;
          state_next  = ST_SERVE;
        end
      end
      ST_OVER: begin
        game_over_next = 1'b1;
        in_play_next   = 1'b0;
      end
      default: state_next = ST_SERVE;
    endcase
  end

endmodule
